// File: rtl/nn_pkg.sv
// Shared definitions for the NN datapath blocks: FSM state encodings and
// parameter helper functions.
package nn_pkg;

    // relu_serializer FSM states
    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_SEND = 1'b1
    } rs_state_e;

    // ceil(log2(n)) clamped to at least 1, so single-entry indices stay legal
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = (n <= 1) ? 1 : int'($clog2(n));
        return r;
    endfunction

endpackage : nn_pkg

// File: rtl/relu_requant.sv
// ReLU followed by a right-shift requantise on one element.
// Ports:
//   x  in   WIDTH  signed two's-complement accumulator element
//   y  out  WIDTH  unsigned result: 0 for negative x, else x >> SHIFT
module relu_requant #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 0
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // x is non-negative whenever it is shifted, so a logical shift is exact
    always_comb begin
        y = '0;
        if (!x[WIDTH-1]) begin
            y = x >> SHIFT;
        end
    end

endmodule : relu_requant

// File: rtl/relu_serializer.sv
// Captures one SIZE-element vector from the MAC array, applies ReLU plus
// requantise, and streams the elements one per beat over valid/ready.
// Vectors offered while busy are dropped and flagged in a sticky bit.
// Ports:
//   clk        in   1           clock, posedge
//   reset      in   1           async active-low reset
//   in_valid   in   1           vector offered (MAC-array done pulse)
//   in_data    in   WIDTH*SIZE  element i at [WIDTH*i +: WIDTH]
//   in_ready   out  1           vector would be captured this cycle
//   out_valid  out  1           beat valid
//   out_ready  in   1           consumer accepts beat
//   out_data   out  WIDTH       processed element
//   out_index  out  IW          element number
//   out_last   out  1           beat carries element SIZE-1
//   dropped    out  1           sticky: vector offered while not ready
module relu_serializer
    import nn_pkg::*;
#(
    parameter int unsigned SIZE  = 6,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 0,
    localparam int unsigned IW   = clog2_min1(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH*SIZE-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  dropped
);

    rs_state_e        state_q;
    logic [WIDTH-1:0] data_q [SIZE];
    logic [IW-1:0]    idx_q;
    logic             last_q;
    logic             dropped_q;

    logic [WIDTH-1:0] proc_c [SIZE];
    logic             fire_c;
    logic             capture_c;

    // Per-element ReLU/requantise on the incoming vector
    for (genvar i = 0; i < int'(SIZE); i++) begin : g_requant
        relu_requant #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT)
        ) u_relu_requant (
            .x (in_data[WIDTH*i +: WIDTH]),
            .y (proc_c[i])
        );
    end

    // last_q is only ever set in SEND, so (out_ready & last_q) is the
    // "last beat is leaving now" condition that allows a bubble-free capture.
    // Gated by reset so the port reads 0 while reset is held.
    always_comb begin
        in_ready  = reset & ((state_q == RS_IDLE) | (out_ready & last_q));
        fire_c    = (state_q == RS_SEND) & out_ready;
        capture_c = in_valid & in_ready;
    end

    // FSM, element buffer, index counter and sticky drop flag.
    // The buffer shifts down on each beat so element idx always sits in
    // data_q[0] and out_data comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RS_IDLE;
            idx_q     <= '0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
            for (int i = 0; i < int'(SIZE); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (capture_c) begin
                state_q <= RS_SEND;
                data_q  <= proc_c;
                idx_q   <= '0;
                last_q  <= (SIZE == 1);
            end else if (fire_c && last_q) begin
                state_q <= RS_IDLE;
                idx_q   <= '0;
                last_q  <= 1'b0;
            end else if (fire_c) begin
                for (int i = 0; i < int'(SIZE) - 1; i++) begin
                    data_q[i] <= data_q[i+1];
                end
                idx_q  <= idx_q + IW'(1);
                last_q <= (idx_q == IW'(SIZE - 2));
            end

            if (in_valid && !in_ready) begin
                dropped_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == RS_SEND);
        out_data  = data_q[0];
        out_index = idx_q;
        out_last  = last_q;
        dropped   = dropped_q;
    end

endmodule : relu_serializer
